// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  localparam logic [15:0] NOP_INSTR   = 16'h0000;
  localparam int          REG_AW_DEF  = 3;
  localparam int          MUL_LAT_DEF = 4;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID instruction and a load in EX.
module load_use_detect #(
  parameter int REG_AW = hazard_pkg::REG_AW_DEF
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  output logic              hazard
);

  logic rs_hit;
  logic rt_hit;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    rs_hit = id_uses_rs && (id_rs == ex_rd);
    rt_hit = id_uses_rt && (id_rt == ex_rd);
    hazard = ex_mem_read && (ex_rd != '0) && id_valid && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline control unit: decides advance/hold/bubble/flush for PC, IF/ID, ID/EX
// and freeze for the back end, and counts front-end stall cycles.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  input  logic              mul_start,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              pc_redirect,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_cycles
);

  // MUL_LAT-3 wait cycles follow the mul_start cycle and the final mcnt==0 cycle.
  localparam logic [3:0] MCNT_INIT = (MUL_LAT > 2) ? 4'(MUL_LAT - 3) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             load_use;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .hazard      (load_use)
  );

  always_comb begin
    pc_write    = 1'b1;
    pc_redirect = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = state_q;
    mcnt_d      = mcnt_q;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      mcnt_d      = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            // A pending branch stays in EX and redirects once memory is ready.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            pipe_freeze = 1'b1;
          end else if (branch_taken) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (mul_start) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            if (MUL_LAT > 2) begin
              state_d = MUL_WAIT;
              mcnt_d  = MCNT_INIT;
            end
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MUL_WAIT: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          pipe_freeze = mem_busy;
          if (!mem_busy) begin
            if (mcnt_q == 4'd0) state_d = RUN;
            else                mcnt_d  = mcnt_q - 4'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      mcnt_q         <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mcnt_q         <= mcnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MUL_LAT=4).
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        ex_mem_read, branch_taken, mul_start, mem_busy;
  logic        pc_write, pc_redirect, ifid_write, ifid_flush;
  logic        idex_write, idex_bubble, pipe_freeze;
  logic [15:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  hazard_stall_ctrl #(.REG_AW(3), .MUL_LAT(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .mul_start    (mul_start),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .pc_redirect  (pc_redirect),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .pipe_freeze  (pipe_freeze),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && mul_start && branch_taken) begin
      fails++;
      $error("FAIL illegal_input: mul_start and branch_taken both 1");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rs = 0; id_rt = 0; ex_rd = 0;
    ex_mem_read = 0; branch_taken = 0; mul_start = 0; mem_busy = 0;
  endtask

  task automatic set_load_use_rt3();
    ex_mem_read = 1; ex_rd = 3; id_valid = 1; id_uses_rt = 1; id_rt = 3;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    #2;
    check("rst_pc_write",    pc_write,    0);
    check("rst_ifid_write",  ifid_write,  0);
    check("rst_ifid_flush",  ifid_flush,  1);
    check("rst_idex_write",  idex_write,  1);
    check("rst_idex_bubble", idex_bubble, 1);
    check("rst_pipe_freeze", pipe_freeze, 0);
    check("rst_redirect",    pc_redirect, 0);
    tick(); tick();
    rst = 0;
    #2;
    check("run_pc_write",   pc_write,     1);
    check("run_ifid_write", ifid_write,   1);
    check("run_ifid_flush", ifid_flush,   0);
    check("run_bubble",     idex_bubble,  0);
    check("run_stall0",     stall_cycles, 0);

    // load-use on rt
    tick();
    set_load_use_rt3();
    #2;
    check("lu_pc_write",   pc_write,    0);
    check("lu_ifid_write", ifid_write,  0);
    check("lu_bubble",     idex_bubble, 1);
    check("lu_idex_write", idex_write,  1);
    tick();
    ex_rd = 0; id_rt = 0;
    #2;
    check("lu_stall1",      stall_cycles, 1);
    check("lu_r0_pc_write", pc_write,     1);
    check("lu_r0_bubble",   idex_bubble,  0);
    // load-use on rs
    tick();
    id_uses_rt = 0; id_uses_rs = 1; id_rs = 5; ex_rd = 5;
    #2;
    check("lu_rs_pc_write", pc_write, 0);
    tick();
    clear_inputs();
    #2;
    check("lu_stall2", stall_cycles, 2);

    // branch wins over a simultaneous load-use
    set_load_use_rt3();
    branch_taken = 1;
    #2;
    check("br_redirect", pc_redirect, 1);
    check("br_flush",    ifid_flush,  1);
    check("br_bubble",   idex_bubble, 1);
    check("br_pc_write", pc_write,    1);
    tick();
    clear_inputs();
    #2;
    check("br_stall2",    stall_cycles, 2);
    check("br_redirect0", pc_redirect,  0);

    // MUL: 3 frozen cycles
    mul_start = 1;
    #2;
    check("mul_c1_pc_write",   pc_write,   0);
    check("mul_c1_idex_write", idex_write, 0);
    tick();
    mul_start = 0;
    branch_taken = 1;
    #2;
    check("mul_c2_pc_write", pc_write,    0);
    check("mul_c2_redirect", pc_redirect, 0);
    check("mul_c2_freeze",   pipe_freeze, 0);
    tick();
    branch_taken = 0;
    #2;
    check("mul_c3_pc_write", pc_write, 0);
    tick();
    #2;
    check("mul_done_pc_write", pc_write,     1);
    check("mul_stall5",        stall_cycles, 5);

    // MUL with 2 busy cycles mid-wait
    mul_start = 1;
    #2;
    check("mb_c1_pc_write", pc_write,    0);
    check("mb_c1_freeze",   pipe_freeze, 0);
    tick();
    mul_start = 0; mem_busy = 1;
    #2;
    check("mb_c2_pc_write", pc_write,    0);
    check("mb_c2_freeze",   pipe_freeze, 1);
    tick();
    #2;
    check("mb_c3_pc_write", pc_write,    0);
    check("mb_c3_freeze",   pipe_freeze, 1);
    tick();
    mem_busy = 0;
    #2;
    check("mb_c4_pc_write", pc_write,    0);
    check("mb_c4_freeze",   pipe_freeze, 0);
    tick();
    #2;
    check("mb_c5_pc_write", pc_write,    0);
    check("mb_c5_freeze",   pipe_freeze, 0);
    tick();
    #2;
    check("mb_done_pc_write", pc_write,     1);
    check("mb_stall10",       stall_cycles, 10);

    // mem_busy holds a taken branch until memory is ready
    mem_busy = 1; branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("busy_redirect", pc_redirect, 0);
      check("busy_flush",    ifid_flush,  0);
      check("busy_freeze",   pipe_freeze, 1);
      check("busy_pc_write", pc_write,    0);
      tick();
    end
    mem_busy = 0;
    #2;
    check("busy_end_redirect", pc_redirect,  1);
    check("busy_end_flush",    ifid_flush,   1);
    check("busy_end_pc_write", pc_write,     1);
    check("busy_stall13",      stall_cycles, 13);
    tick();
    clear_inputs();

    // reset during MUL_WAIT discards the remaining count
    mul_start = 1;
    tick();
    mul_start = 0;
    rst = 1;
    #2;
    check("rmul_pc_write", pc_write,    0);
    check("rmul_bubble",   idex_bubble, 1);
    check("rmul_flush",    ifid_flush,  1);
    tick();
    rst = 0;
    #2;
    check("rmul_run_pc_write", pc_write,     1);
    check("rmul_stall0",       stall_cycles, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
